bram_dp_be: RTL

BRAM_DP_BE -- requirements
Module: bram_dp_be

---
 rtl/bram_pkg.sv | 14 +
 rtl/bram_clear_fsm.sv | 48 ++++
 rtl/bram_dp_be.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/bram_pkg.sv
// Shared constants and helpers for the dual-port byte-enable RAM.
package bram_pkg;
  localparam int RDW_NEW = 0;
  localparam int RDW_OLD = 1;

  function automatic int lanes(input int data_w);
    return data_w / 8;
  endfunction

  // Even parity: the stored bit makes the 9-bit group have an even count of ones.
  function automatic logic par8(input logic [7:0] b);
    return ^b;
  endfunction
endpackage

// File: rtl/bram_clear_fsm.sv
// Zero-fill sequencer: IDLE/CLEAR FSM walking an address counter over every word.
module bram_clear_fsm
  import bram_pkg::*;
#(
  parameter int DEPTH          = 8192,
  parameter int ADDR_W         = 13,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic              busy,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              clr_we
);
  typedef enum logic {IDLE, CLEAR} state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t state;
  logic   pend;

  // pend holds busy high from reset until the first edge launches the fill.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      pend     <= CLEAR_ON_RESET;
      clr_addr <= '0;
    end else begin
      pend <= 1'b0;
      case (state)
        IDLE: if (start || pend) begin
          state    <= CLEAR;
          clr_addr <= '0;
        end
        CLEAR: if (clr_addr == LAST) begin
          state    <= IDLE;
          clr_addr <= '0;
        end else begin
          clr_addr <= clr_addr + 1'b1;
        end
      endcase
    end
  end

  assign clr_we = (state == CLEAR);
  assign busy   = clr_we | pend;
endmodule

// File: rtl/bram_dp_be.sv
// Dual-port RAM: port A byte-enable read/write, port B read-only, built-in zero-fill.
// Define BRAM_PARITY_EN to add per-byte even parity storage and the parity_err output.
module bram_dp_be
  import bram_pkg::*;
#(
  parameter int DATA_W         = 16,
  parameter int DEPTH          = 8192,
  parameter int ADDR_W         = $clog2(DEPTH),
  parameter bit OUT_REG        = 1'b0,
  parameter int RDW_MODE       = RDW_NEW,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   a_addr,
  input  logic [DATA_W-1:0]   a_wdata,
  input  logic [DATA_W/8-1:0] a_be,
  input  logic                a_wr,
  input  logic                a_rd,
  output logic [DATA_W-1:0]   a_rdata,
  output logic                a_valid,
  input  logic [ADDR_W-1:0]   b_addr,
  input  logic                b_rd,
  output logic [DATA_W-1:0]   b_rdata,
  output logic                b_valid,
  input  logic                clear_start,
  output logic                busy
`ifdef BRAM_PARITY_EN
  ,
  output logic [DATA_W/8-1:0] parity_err
`endif
);
  localparam int NL     = lanes(DATA_W);
  localparam int IW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int STAGES = OUT_REG ? 2 : 1;

  logic [DATA_W-1:0] mem [DEPTH];
`ifdef BRAM_PARITY_EN
  logic [NL-1:0]     par_mem [DEPTH];
`endif

  logic [ADDR_W-1:0] clr_addr;
  logic              clr_we;
  logic [IW-1:0]     a_idx, b_idx, clr_idx;
  logic              a_ok, b_ok, wr_en, b_hit;
  logic [DATA_W-1:0] a_old, b_old, a_mrg, a_sel, b_sel;
  logic [1:0]        rd_acc;
  logic              unused_clr_hi;

  logic [1:0][STAGES:1]             vld_pipe;
  logic [1:0][STAGES:1][DATA_W-1:0] dat_pipe;

  bram_clear_fsm #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .CLEAR_ON_RESET(CLEAR_ON_RESET)
  ) u_clr (
    .clk(clk), .reset_n(reset_n), .start(clear_start),
    .busy(busy), .clr_addr(clr_addr), .clr_we(clr_we)
  );

  assign a_idx         = a_addr[IW-1:0];
  assign b_idx         = b_addr[IW-1:0];
  assign clr_idx       = clr_addr[IW-1:0];
  assign unused_clr_hi = ^clr_addr;
  assign a_ok          = 32'(a_addr) < DEPTH;
  assign b_ok          = 32'(b_addr) < DEPTH;
  assign wr_en         = a_wr & ~busy & a_ok;
  assign b_hit         = wr_en & (a_addr == b_addr);
  assign rd_acc        = {b_rd & ~busy, a_rd & ~busy};

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_idx] <= '0;
`ifdef BRAM_PARITY_EN
      par_mem[clr_idx] <= '0;
`endif
    end else if (wr_en) begin
      for (int i = 0; i < NL; i++)
        if (a_be[i]) begin
          mem[a_idx][8*i +: 8] <= a_wdata[8*i +: 8];
`ifdef BRAM_PARITY_EN
          par_mem[a_idx][i] <= par8(a_wdata[8*i +: 8]);
`endif
        end
    end
  end

  assign a_old = mem[a_idx];
  assign b_old = mem[b_idx];

  // Merged word for a same-address write: enabled lanes new, the rest old.
  always_comb begin
    a_mrg = a_old;
    for (int i = 0; i < NL; i++)
      if (a_be[i]) a_mrg[8*i +: 8] = a_wdata[8*i +: 8];
  end

  assign a_sel = !a_ok ? '0 : (wr_en && RDW_MODE == RDW_NEW) ? a_mrg : a_old;
  assign b_sel = !b_ok ? '0 : (b_hit && RDW_MODE == RDW_NEW) ? a_mrg : b_old;

  // Data stages load only on a valid read so outputs hold between reads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        vld_pipe[p][1] <= rd_acc[p];
        if (rd_acc[p]) dat_pipe[p][1] <= (p == 0) ? a_sel : b_sel;
        for (int s = 2; s <= STAGES; s++) begin
          vld_pipe[p][s] <= vld_pipe[p][s-1];
          if (vld_pipe[p][s-1]) dat_pipe[p][s] <= dat_pipe[p][s-1];
        end
      end
    end
  end

  assign a_valid = vld_pipe[0][STAGES];
  assign a_rdata = dat_pipe[0][STAGES];
  assign b_valid = vld_pipe[1][STAGES];
  assign b_rdata = dat_pipe[1][STAGES];

`ifdef BRAM_PARITY_EN
  logic [NL-1:0]                err_a, err_b, a_pold, b_pold, a_pmrg, a_psel, b_psel;
  logic [1:0][STAGES:1][NL-1:0] err_pipe;

  assign a_pold = par_mem[a_idx];
  assign b_pold = par_mem[b_idx];

  always_comb begin
    a_pmrg = a_pold;
    for (int i = 0; i < NL; i++)
      if (a_be[i]) a_pmrg[i] = par8(a_wdata[8*i +: 8]);
  end

  assign a_psel = !a_ok ? '0 : (wr_en && RDW_MODE == RDW_NEW) ? a_pmrg : a_pold;
  assign b_psel = !b_ok ? '0 : (b_hit && RDW_MODE == RDW_NEW) ? a_pmrg : b_pold;

  always_comb begin
    err_a = '0;
    err_b = '0;
    for (int i = 0; i < NL; i++) begin
      err_a[i] = par8(a_sel[8*i +: 8]) ^ a_psel[i];
      err_b[i] = par8(b_sel[8*i +: 8]) ^ b_psel[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_pipe <= '0;
    end else begin
      if (rd_acc[0]) err_pipe[0][1] <= err_a;
      if (rd_acc[1]) err_pipe[1][1] <= err_b;
      for (int p = 0; p < 2; p++)
        for (int s = 2; s <= STAGES; s++)
          if (vld_pipe[p][s-1]) err_pipe[p][s] <= err_pipe[p][s-1];
    end
  end

  assign parity_err = (a_valid ? err_pipe[0][STAGES] : '0) |
                      (b_valid ? err_pipe[1][STAGES] : '0);
`endif
endmodule
